// File: rtl/spi_pkg.sv
// Shared encodings for the SPI command master and the RAM-side slave wrapper.
package spi_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StShift,
        StTurn,
        StRecv,
        StGap
    } master_state_t;

    // Read-data frames carry no payload; the slave expects zeros there.
    function automatic logic [FRAME_W-1:0] pack_word(input op_t op,
                                                     input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] payload;
        payload = (op == OP_RD_DATA) ? '0 : data;
        return {op, payload};
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shifter, MSB first: serial out from the top bit, serial in at the bottom.
module spi_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_serial,
    output logic             o_serial,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], i_serial};
        end
    end

    assign o_serial = r_data[WIDTH-1];
    assign o_data   = r_data;

endmodule

// File: rtl/spi_cmd_master.sv
// Command-driven SPI master: serialises one {op, data} frame per host handshake and
// captures the slave's reply byte on read-data frames.
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_busy,
    output logic              o_ss_n,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam logic [3:0] LAST_BIT  = 4'(FRAME_W - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
    localparam logic [3:0] RECV_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);

    master_state_t     r_state;
    op_t               r_op;
    logic [3:0]        r_cnt;
    logic              r_cmd_ready;
    logic              r_ss_n;
    logic              r_mosi;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic               w_accept;
    logic               w_tx_shift;
    logic               w_tx_msb;
    logic               w_rx_shift;
    logic               w_rx_msb;
    logic [FRAME_W-1:0] w_word;
    logic [FRAME_W-1:0] w_tx_data;
    logic [DATA_W-1:0]  w_rx_data;
    logic               w_unused;

    assign w_accept   = (r_state == StIdle) && r_cmd_ready && i_cmd_valid;
    assign w_word     = pack_word(op_t'(i_cmd_op), i_cmd_data);
    // The SEL cycle repeats word[9], so the shifter advances one bit ahead of MOSI.
    assign w_tx_shift = (r_state == StSel) || ((r_state == StShift) && (r_cnt != LAST_BIT));
    assign w_rx_shift = (r_state == StRecv);
    assign w_unused   = ^{w_tx_data, w_rx_msb};

    spi_shift_reg #(
        .WIDTH(FRAME_W)
    ) u_tx_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_load_data(w_word),
        .i_shift    (w_tx_shift),
        .i_serial   (1'b0),
        .o_serial   (w_tx_msb),
        .o_data     (w_tx_data)
    );

    spi_shift_reg #(
        .WIDTH(DATA_W)
    ) u_rx_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (1'b0),
        .i_load_data('0),
        .i_shift    (w_rx_shift),
        .i_serial   (i_miso),
        .o_serial   (w_rx_msb),
        .o_data     (w_rx_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_op        <= OP_WR_ADDR;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_state     <= StSel;
                        r_op        <= op_t'(i_cmd_op);
                        r_cmd_ready <= 1'b0;
                        r_ss_n      <= 1'b0;
                        r_mosi      <= i_cmd_op[1];
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                StSel: begin
                    r_state <= StShift;
                    r_cnt   <= '0;
                    r_mosi  <= w_tx_msb;
                end
                StShift: begin
                    if (r_cnt == LAST_BIT) begin
                        r_cnt  <= '0;
                        r_mosi <= 1'b0;
                        if (r_op == OP_RD_DATA) begin
                            r_state <= StTurn;
                        end else begin
                            r_state <= StGap;
                            r_ss_n  <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_mosi <= w_tx_msb;
                    end
                end
                StTurn: begin
                    if (r_cnt == TURN_LAST) begin
                        r_cnt   <= '0;
                        r_state <= StRecv;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                StRecv: begin
                    if (r_cnt == RECV_LAST) begin
                        // Last sample goes straight into the response, bypassing the shifter.
                        r_cnt       <= '0;
                        r_state     <= StGap;
                        r_ss_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {w_rx_data[DATA_W-2:0], i_miso};
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                StGap: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= StIdle;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_ss_n      = r_ss_n;
    assign o_mosi      = r_mosi;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != StIdle) && !i_rst;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master with a behavioural SPI slave + RAM model on the pins.
module tb_spi_cmd_master;

    localparam int TURN = 1;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       miso;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ss_n;
    logic       mosi;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    spi_cmd_master #(
        .TURN_CYC(TURN),
        .GAP_CYC (GAP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op   (cmd_op),
        .i_cmd_data (cmd_data),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data (rsp_data),
        .o_busy     (busy),
        .o_ss_n     (ss_n),
        .o_mosi     (mosi),
        .i_miso     (miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: low_cnt numbers the SS_n-low cycles of the current frame from 1.
    logic [7:0]  ram [256];
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  rd_addr = 8'h00;
    logic [7:0]  tx_byte = 8'h00;
    logic [9:0]  rx_word = '0;
    logic [19:0] mosi_seq = '0;
    logic        prev_low = 1'b0;
    int          low_cnt = 0;
    int          hi_cnt = 0;
    int          rsp_cnt = 0;
    int          rsp_hi = 0;
    logic [7:0]  rsp_last = 8'h00;

    initial miso = 1'b0;

    always @(negedge clk) begin : slave_model
        int         n;
        int         h;
        logic [9:0] w;
        n = prev_low ? low_cnt + 1 : 1;
        h = prev_low ? 1 : hi_cnt + 1;
        w = {rx_word[8:0], mosi};
        if (!ss_n) begin
            low_cnt  <= n;
            mosi_seq <= prev_low ? {mosi_seq[18:0], mosi} : {19'd0, mosi};
            if (n >= 2 && n <= 11) rx_word <= w;
            if (n == 11) begin
                case (w[9:8])
                    2'b00:   wr_addr <= w[7:0];
                    2'b01:   ram[wr_addr] <= w[7:0];
                    2'b10:   rd_addr <= w[7:0];
                    default: tx_byte <= ram[rd_addr];
                endcase
            end
            miso <= (n >= 12 + TURN && n < 20 + TURN) ? tx_byte[7 - (n - 12 - TURN)] : 1'b0;
        end else begin
            hi_cnt <= h;
            miso   <= 1'b0;
        end
        prev_low <= !ss_n;
        if (rsp_valid) begin
            rsp_cnt  <= rsp_cnt + 1;
            rsp_last <= rsp_data;
            rsp_hi   <= ss_n ? h : 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_accept(output int t);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'd1);
        step();
        t = cyc;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int t;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_accept(t);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout: observed no end of test, required $finish");
        $fatal(1);
    end

    initial begin : stimulus
        int r0;
        int t0, t1, t2, t3;

        // Reset
        repeat (3) step();
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write address A5
        r0 = rsp_cnt;
        send(2'b00, 8'hA5);
        check("wa_busy", 32'(busy), 32'd1);
        check("wa_ss_low", 32'(ss_n), 32'd0);
        wait_idle();
        check("wa_low_cycles", 32'(low_cnt), 32'd11);
        check("wa_mosi_seq", 32'(mosi_seq), 32'h000A5);
        check("wa_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        check("wa_ready_back", 32'(cmd_ready), 32'd1);

        // Write data 3C, read address A5
        send(2'b01, 8'h3C);
        wait_idle();
        check("wd_low_cycles", 32'(low_cnt), 32'd11);
        check("wd_mosi_seq", 32'(mosi_seq), 32'h0013C);
        send(2'b10, 8'hA5);
        wait_idle();
        check("ra_mosi_seq", 32'(mosi_seq), 32'h006A5);
        check("ra_no_rsp", 32'(rsp_cnt - r0), 32'd0);

        // Read data: payload byte must go out as zeros
        send(2'b11, 8'hFF);
        wait_idle();
        check("rd_low_cycles", 32'(low_cnt), 32'd20);
        check("rd_mosi_seq", 32'(mosi_seq), 32'hE0000);
        check("rd_rsp_count", 32'(rsp_cnt - r0), 32'd1);
        check("rd_rsp_last", 32'(rsp_last), 32'h3C);
        check("rd_rsp_with_ss_high", 32'(rsp_hi), 32'd1);
        check("rd_rsp_data_hold", 32'(rsp_data), 32'h3C);
        check("rd_rsp_valid_low", 32'(rsp_valid), 32'd0);

        // Back-to-back end-to-end with cmd_valid held high
        r0 = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_op = 2'b00; cmd_data = 8'h10;
        wait_accept(t0);
        cmd_op = 2'b01; cmd_data = 8'h5A;
        wait_accept(t1);
        cmd_op = 2'b10; cmd_data = 8'h10;
        wait_accept(t2);
        cmd_op = 2'b11; cmd_data = 8'h00;
        wait_accept(t3);
        cmd_valid = 1'b0;
        check("b2b_gap_1", 32'(t1 - t0), 32'd13);
        check("b2b_gap_2", 32'(t2 - t1), 32'd13);
        check("b2b_gap_3", 32'(t3 - t2), 32'd13);
        wait_idle();
        check("b2b_low_cycles", 32'(low_cnt), 32'd20);
        check("b2b_rsp_count", 32'(rsp_cnt - r0), 32'd1);
        check("b2b_rsp_data", 32'(rsp_data), 32'h5A);

        // Reset at SHIFT bit 4 of a read-data frame
        r0 = rsp_cnt;
        send(2'b11, 8'h00);
        repeat (5) step();
        check("mid_at_bit4", 32'(low_cnt), 32'd6);
        rst = 1'b1;
        #1;
        check("mid_ss_n", 32'(ss_n), 32'd1);
        check("mid_mosi", 32'(mosi), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rsp_data", 32'(rsp_data), 32'h00);
        repeat (2) step();
        rst = 1'b0;
        repeat (30) step();
        check("mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);
        send(2'b11, 8'h00);
        wait_idle();
        check("post_low_cycles", 32'(low_cnt), 32'd20);
        check("post_rsp_count", 32'(rsp_cnt - r0), 32'd1);
        check("post_rsp_data", 32'(rsp_data), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
